// File: rtl/alu_dispatcher.sv
// Command stage for the multi-cycle ALU: queues {A, B, mode, tag} commands, issues them one at a
// time with a single-cycle valid pulse, and returns each result (or a local error) with its tag.
module alu_dispatcher #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [3:0]       cmd_mode,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             alu_valid,
  output logic [31:0]      alu_in_A,
  output logic [31:0]      alu_in_B,
  output logic [3:0]       alu_mode,
  input  logic             alu_ready,
  input  logic [63:0]      alu_out_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err
);

  // state | meaning
  // IDLE  | waiting for a queued command; pops the head when one is present
  // ISSUE | alu_valid high for this single cycle
  // WAIT  | operands held, waiting for the ALU ready pulse
  // DONE  | response held until rsp_ready

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 68 + TAG_W;
  localparam logic [3:0] MAX_MODE = 4'b1010;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [EW-1:0]    mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             full, empty, push, pop;
  logic [31:0]      head_a, head_b;
  logic [3:0]       head_mode;
  logic [TAG_W-1:0] head_tag;

  state_t           state_q, state_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [3:0]       mode_q, mode_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [63:0]      rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_err_q, rsp_err_d;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = cmd_valid && !full;
  assign {head_a, head_b, head_mode, head_tag} = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = {cmd_a, cmd_b, cmd_mode, cmd_tag};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    a_d        = a_q;
    b_d        = b_q;
    mode_d     = mode_q;
    tag_d      = tag_q;
    rsp_data_d = rsp_data_q;
    rsp_tag_d  = rsp_tag_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop   = 1'b1;
          tag_d = head_tag;
          if (head_mode <= MAX_MODE) begin
            a_d     = head_a;
            b_d     = head_b;
            mode_d  = head_mode;
            state_d = ISSUE;
          end else begin
            // Unsupported opcode: answer locally, the ALU is never touched.
            rsp_err_d  = 1'b1;
            rsp_data_d = 64'd0;
            rsp_tag_d  = head_tag;
            state_d    = DONE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (alu_ready) begin
          rsp_data_d = alu_out_data;
          rsp_err_d  = 1'b0;
          rsp_tag_d  = tag_q;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      mode_q     <= '0;
      tag_q      <= '0;
      rsp_data_q <= '0;
      rsp_tag_q  <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mode_q     <= mode_d;
      tag_q      <= tag_d;
      rsp_data_q <= rsp_data_d;
      rsp_tag_q  <= rsp_tag_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign cmd_ready = !full;
  assign alu_valid = (state_q == ISSUE);
  assign alu_in_A  = a_q;
  assign alu_in_B  = b_q;
  assign alu_mode  = mode_q;
  assign rsp_valid = (state_q == DONE);
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_err   = rsp_err_q;

endmodule
